// File: rtl/adc_pkg.sv
// Shared frame geometry, FSM state type and frame decode helpers for the
// serial ADC sequencer.
package adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 12;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_QUIET
    } state_e;

    // The converter always sends LEAD_ZEROS zero bits ahead of the data.
    // Any one set there means the frame cannot be trusted.
    function automatic logic frame_error(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
    endfunction

    function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_BITS-1:0] frame);
        return frame[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running conversion period timer. It counts only while enabled, and
// restarts from zero each time it is enabled, so that the first tick comes a
// full period after enable.
module adc_period_timer #(
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the end of the period, hold at zero when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Conversion sequencer for the 12-bit serial ADC. It generates cs/sclk as
// registered clk-domain outputs, shifts in one 16-bit frame per trigger and
// presents the 12-bit result with a one-cycle valid strobe.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              clr_ovr,
    input  logic              sdata,
    output logic              cs,
    output logic              sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              busy,
    output logic              overrun
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("adc_sample_ctrl: CLK_DIV must be at least 1");
    end
    if (SAMPLE_PERIOD < 35 * CLK_DIV + 2) begin : g_bad_period
        $error("adc_sample_ctrl: SAMPLE_PERIOD too short for one frame");
    end

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [HW-1:0]           half_q, half_d;
    logic [4:0]              bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic [DATA_W-1:0]       sample_q, sample_d;
    logic                    vld_q, vld_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;
    logic                    tick;
    logic                    trig;
    logic                    half_end;

    adc_period_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    // The software trigger only counts while periodic sampling is off.
    assign trig     = en ? tick : start;
    assign half_end = (half_q == HALF_LAST);

    // Sequencer next state and registered pin/result values.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        sample_d = sample_q;
        ferr_d   = ferr_q;
        vld_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                half_d = '0;
                bit_d  = '0;
                if (trig) begin
                    state_d = ST_SETUP;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (half_end) begin
                    half_d  = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_end) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        // Rising sclk edge: this is where the ADC bit is stable.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[FRAME_BITS-2:0], sdata};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_DONE: begin
                cs_d     = 1'b1;
                sample_d = frame_data(shift_q);
                ferr_d   = frame_error(shift_q);
                vld_d    = 1'b1;
                half_d   = '0;
                bit_d    = '0;
                state_d  = ST_QUIET;
            end
            ST_QUIET: begin
                if (half_end) begin
                    half_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    // Overrun is sticky; a dropped trigger beats a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        if (trig && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // Control and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            half_q   <= '0;
            bit_q    <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            sample_q <= '0;
            vld_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // Frame shift register; its contents matter only once a frame completes.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign cs           = cs_q;
    assign sclk         = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = vld_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Self-checking bench for adc_sample_ctrl: an ADC pin model plus a
// cycle-timeline reference model derived from the frame timing rules.
module tb_adc_sample_ctrl;

    localparam int H  = 4;
    localparam int SP = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        clr_ovr = 1'b0;
    logic        sdata = 1'b0;
    logic        cs, sclk, sample_valid, frame_err, busy, overrun;
    logic [11:0] sample;

    adc_sample_ctrl #(
        .CLK_DIV      (H),
        .SAMPLE_PERIOD(SP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .clr_ovr     (clr_ovr),
        .sdata       (sdata),
        .cs          (cs),
        .sclk        (sclk),
        .sample      (sample),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle edge)", tag, got, exp);
        end
    endtask

    // ADC pin model: presents the next frame bit after each falling sclk.
    logic [15:0] adc_word = 16'h0;
    int          adc_idx = 0;
    logic        adc_prev_sclk = 1'b1;
    always @(posedge clk) begin
        #1;
        if (cs) begin
            adc_idx = 0;
        end else if (adc_prev_sclk && !sclk && adc_idx < 16) begin
            sdata = adc_word[15 - adc_idx];
            adc_idx++;
        end
        adc_prev_sclk = sclk;
    end

    // Reference model: a frame is a timeline anchored at the edge e0 where
    // cs falls; all outputs follow from the offset of the current edge.
    int          cyc = 0;
    int          run = 0;
    int          e0 = 0;
    bit          act = 0;
    bit          m_ovr = 0;
    bit          m_ferr = 0;
    logic [11:0] m_sample = 12'h0;
    logic [15:0] fw = 16'h0;
    logic [15:0] force_word = 16'h0;
    bit          force_en = 0;

    int   rises = 0;
    int   cs_falls = 0;
    int   valid_cyc = -1;
    logic sclk_obs = 1'b1;
    logic cs_obs = 1'b1;

    function automatic logic [31:0] expected();
        int   d = cyc - e0;
        bit   inf = act && (d >= 0);
        logic e_cs   = !(inf && d <= 32 * H);
        logic e_sclk = !(inf && d >= H && d < 32 * H && ((d / H) % 2 == 1));
        logic e_busy = inf && d <= 33 * H;
        logic e_vld  = inf && d == 32 * H + 1;
        return {14'd0, e_cs, e_sclk, e_busy, e_vld, m_ovr, m_ferr, m_sample};
    endfunction

    task automatic model_step();
        int e = cyc + 1;
        bit trig;
        bit was_busy;
        trig     = en ? ((run % SP) == SP - 1) : start;
        run      = en ? run + 1 : 0;
        was_busy = act && ((cyc - e0) <= 33 * H);
        if (trig && was_busy) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (trig && !was_busy) begin
            act = 1;
            e0  = e;
            if (force_en) begin
                fw       = force_word;
                force_en = 0;
            end else begin
                fw = 16'($urandom);
                if ($urandom_range(0, 1) == 1) fw[15:12] = 4'h0;
            end
            adc_word = fw;
        end
        if (act && e == e0 + 32 * H + 1) begin
            m_sample = fw[11:0];
            m_ferr   = |fw[15:12];
        end
    endtask

    // One clock: advance the model with the inputs now applied, then compare.
    task automatic cycle();
        if (rst) begin
            act = 0; run = 0; m_ovr = 0; m_ferr = 0; m_sample = 12'h0;
        end else begin
            model_step();
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cs_obs && !cs) begin
            cs_falls++;
            rises = 0;
        end
        if (!cs && sclk && !sclk_obs) rises++;
        if (sample_valid) begin
            valid_cyc = cyc;
            check("sclk_rises", rises, 16);
            rises = 0;
        end
        sclk_obs = sclk;
        cs_obs   = cs;
        check("outs", {14'd0, cs, sclk, busy, sample_valid, overrun, frame_err, sample}, expected());
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(input int limit, input string tag);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            cycle();
            seen = sample_valid;
        end
        check(tag, seen, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    int t_en;
    int falls0;
    bit got;

    initial begin
        // Reset state
        cycle();
        cycle();
        check("reset_state", {cs, sclk, busy, sample_valid, overrun, frame_err, sample},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
        rst = 1'b0;
        cycle();

        // Periodic frame returning 0x0ABC, then 0x1FFF
        force_word = 16'h0ABC; force_en = 1;
        en = 1'b1; t_en = cyc;
        wait_valid(SP + 200, "t1_valid");
        check("t1_latency", valid_cyc + 1 - (t_en + SP), 130);
        check("t1_sample", sample, 12'hABC);
        check("t1_ferr", frame_err, 1'b0);
        cycle();
        check("t1_vld_one_cycle", sample_valid, 1'b0);
        force_word = 16'h1FFF; force_en = 1;
        wait_valid(SP + 50, "t2_valid");
        check("t2_sample", sample, 12'hFFF);
        check("t2_ferr", frame_err, 1'b1);

        // start while en=1 is ignored
        run_cycles(2 * H);
        pulse_start();
        run_cycles(20);
        check("t3_no_frame", busy, 1'b0);
        check("t3_no_ovr", overrun, 1'b0);
        en = 1'b0;
        run_cycles(SP);

        // Software trigger
        pulse_start();
        wait_valid(40 * H, "t4_valid");
        check("t4_sample", sample, fw[11:0]);
        run_cycles(2 * H);

        // Overrun, clear, and set-beats-clear
        pulse_start();
        run_cycles(10 * H);
        pulse_start();
        check("t5_ovr_set", overrun, 1'b1);
        wait_valid(40 * H, "t5_valid");
        check("t5_frame_ok", sample, fw[11:0]);
        run_cycles(2 * H);
        clr_ovr = 1'b1; cycle(); clr_ovr = 1'b0;
        check("t5_ovr_clr", overrun, 1'b0);
        pulse_start();
        run_cycles(5 * H);
        start = 1'b1; clr_ovr = 1'b1; cycle(); start = 1'b0; clr_ovr = 1'b0;
        check("t5_set_wins", overrun, 1'b1);
        wait_valid(40 * H, "t5b_valid");
        run_cycles(2 * H);
        clr_ovr = 1'b1; cycle(); clr_ovr = 1'b0;

        // Reset during bit 8
        pulse_start();
        run_cycles(15 * H);
        #2 rst = 1'b1;
        #1 check("t6_async_pins", {cs, sclk, busy}, 3'b110);
        cycle();
        cycle();
        rst = 1'b0;
        run_cycles(40 * H);
        check("t6_sample_zero", sample, 12'h000);

        // Randomised trigger/enable/clear traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            start   = ($urandom_range(0, 39) == 0);
            clr_ovr = ($urandom_range(0, 59) == 0);
            cycle();
        end
        start = 1'b0; clr_ovr = 1'b0; en = 1'b0;
        run_cycles(40 * H);

        // Drop en mid-frame
        en = 1'b1;
        got = 0;
        for (int i = 0; i < SP + 10 && !got; i++) begin
            cycle();
            got = !cs;
        end
        check("t8_cs_fall", got, 1);
        run_cycles(10 * H);
        en = 1'b0;
        wait_valid(40 * H, "t8_valid");
        check("t8_sample", sample, fw[11:0]);
        falls0 = cs_falls;
        run_cycles(3 * SP);
        check("t8_no_more_frames", cs_falls - falls0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Single-clock conversion sequencer for the 12-bit serial Pmod ADC feeding the servo control loop. It generates the periodic conversion trigger, drives `cs` and `sclk` as registered outputs derived from `clk`, shifts in the 16-bit frame and presents the 12-bit result with a one-cycle `sample_valid` strobe. Because every output is produced in the `clk` domain, downstream logic needs no cross-clock edge detection.

## Interface
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles (H); legal range ≥1.
- `SAMPLE_PERIOD`, 2000: `clk` cycles between periodic triggers; must be ≥ 35·H+2 (elaboration-time check).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: periodic sampling enable.
- `start` input 1: one-cycle software trigger; used only when `en`=0.
- `clr_ovr` input 1: clears `overrun`.
- `sdata` input 1: serial data from the ADC.
- `cs` output 1: chip select, active low.
- `sclk` output 1: serial clock, idle high.
- `sample` output 12: last completed conversion.
- `sample_valid` output 1: one-cycle strobe when `sample` updates.
- `frame_err` output 1: leading 4 bits of the last frame were not all zero; updates with `sample`.
- `busy` output 1: high in every state other than IDLE.
- `overrun` output 1: sticky; set when a trigger arrives while `busy`.

## Operation
- Reset values: `cs`=1, `sclk`=1, `sample`=0, `sample_valid`=0, `frame_err`=0, `busy`=0, `overrun`=0, state IDLE, all counters 0.
- Period timer:
  - Counts 0..SAMPLE_PERIOD-1 while `en`=1; held at 0 while `en`=0.
  - Trigger at count SAMPLE_PERIOD-1; the first trigger occurs SAMPLE_PERIOD cycles after `en` rises.
- Trigger source: periodic trigger when `en`=1; `start` pulse when `en`=0. `start` is ignored while `en`=1.
- States:
  - IDLE → SETUP on a trigger.
  - SETUP (`cs`=0, `sclk`=1, H cycles) → SHIFT.
  - SHIFT: 16 bit periods, each `sclk` low for H cycles, then high for H cycles.
  - SHIFT → DONE after the high half of bit 16.
  - DONE (1 cycle) → QUIET.
  - QUIET (`cs`=1, H cycles) → IDLE.
- Capture: `sdata` is shifted into a 16-bit register MSB-first on the `clk` edge that drives `sclk` 0→1.
- DONE cycle:
  - `cs`=1.
  - `sample` ← shift[11:0].
  - `frame_err` ← (shift[15:12] ≠ 0).
  - `sample_valid`=1.
- Trigger while not IDLE: the trigger is dropped and `overrun` is set. If `clr_ovr` and an overrun event occur in the same cycle, set wins.
- `en` deasserted mid-frame: the frame completes and delivers its sample; no further triggers.
- `rst` mid-frame: immediate return to reset values; the partial frame is discarded and no `sample_valid` is issued.

## Timing
- Let E0 be the `clk` edge on which `cs` falls (the edge following the trigger cycle).
- `sclk` falls at E0+H·(2k-1) and rises at E0+2kH, for bit k=1..16.
- Bit k is captured at E0+2kH. Final rise at E0+32H.
- `cs` rises and `sample_valid`=1 after edge E0+32H+1; `sample_valid` is low again after the following edge.
- Trigger-to-valid latency: 32H+2 cycles. `busy` stays high until QUIET completes.
- With H=4 at 100 MHz: `sclk`=12.5 MHz, frame ≈ 1.3 µs.

## Structure
- Package `adc_pkg`:
  - `FRAME_BITS`=16, `DATA_W`=12, `LEAD_ZEROS`=4.
  - State enum (IDLE, SETUP, SHIFT, DONE, QUIET).
- Sub-module `adc_period_timer`: parameter `SAMPLE_PERIOD`, inputs `clk`/`rst`/`en`, output single-cycle `tick`.
- Remaining logic in the top: FSM, H-cycle half-period counter, 5-bit bit counter, shift register.

## Test plan
- H=4, `en`=1, ADC model returns 0x0ABC → `sample`=0xABC, `frame_err`=0, `sample_valid` one cycle exactly 130 cycles after the trigger, 16 `sclk` rising edges per frame.
- Model returns 0x1FFF → `sample`=0xFFF, `frame_err`=1.
- `en`=0, `start` pulse → one frame; `start` while `en`=1 → no extra frame and `overrun` stays 0.
- Force `start` during a frame with `en`=0 → `overrun`=1 and the frame is unaffected; `clr_ovr` then clears `overrun`; simultaneous set and clear leaves `overrun`=1.
- Assert `rst` at bit 8 → `cs`=1, `sclk`=1 and `busy`=0 immediately; no `sample_valid`; `sample` keeps 0.
- Drop `en` mid-frame → the frame completes and delivers its sample; no further `cs` falls for 3·SAMPLE_PERIOD cycles.
